// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, the complex sample type and the
// digit-reversal index helper that both FFT stages use.
package fft_pkg;

    localparam int FFT_DW    = 10;
    localparam int FFT_LOG2R = 3;
    localparam int N         = 1 << (2 * FFT_LOG2R);

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    // Swap the two radix digits of a 2*log2r-bit index: {lo, hi} -> {hi-as-low, lo-as-high}.
    function automatic logic [31:0] digit_rev(input logic [31:0] idx, input int log2r);
        logic [31:0] mask;
        mask = (32'd1 << log2r) - 32'd1;
        return ((idx & mask) << log2r) | ((idx >> log2r) & mask);
    endfunction

endpackage

// File: rtl/fft_bank_ram.sv
// Two-bank sample store: one write port, one synchronous read port.
// The address MSB selects the bank, the remaining bits the sample slot.
module fft_bank_ram #(
    parameter int WIDTH = 20,
    parameter int AW    = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];

    // Store each accepted sample.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; data only moves when the consumer asks for the next sample.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong reorder buffer: writes frames in arrival order into one bank while
// the other bank is read back in digit-reversed (natural frequency) order.
// Optional macro FFT_REORDER_BYPASS_EN adds port reorder_en, sampled at the
// start of each read frame, to select natural (0) or digit-reversed (1) reads.
module fft_reorder_buf
    import fft_pkg::*;
#(
    parameter int DW    = FFT_DW,
    parameter int LOG2R = FFT_LOG2R
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din_re,
    input  logic [DW-1:0] din_im,
    input  logic          din_valid,
    output logic          din_ready,
`ifdef FFT_REORDER_BYPASS_EN
    input  logic          reorder_en,
`endif
    output logic [DW-1:0] dout_re,
    output logic [DW-1:0] dout_im,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          ovf
);

    localparam int AW = 2 * LOG2R;

    logic [AW-1:0]   wcnt;
    logic [AW-1:0]   rcnt;
    logic [AW-1:0]   rd_idx;
    logic            wb;
    logic            rb;
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic            wb_nxt;
    logic            accept;
    logic            wr_wrap;
    logic            adv;
    logic            issue;
    logic            rd_wrap;
    logic            s1_valid;
    logic            s1_last;
    logic [2*DW-1:0] rd_data;

    assign accept  = din_valid && din_ready;
    assign wr_wrap = accept && (wcnt == {AW{1'b1}});
    assign adv     = !dout_valid || dout_ready;
    assign issue   = adv && full[rb];
    assign rd_wrap = issue && (rcnt == {AW{1'b1}});

`ifdef FFT_REORDER_BYPASS_EN
    logic rev_q;
    // Slot 0 maps to address 0 in both modes, so the freshly sampled mode is only needed from slot 1.
    assign rd_idx = rev_q ? AW'(digit_rev(32'(rcnt), LOG2R)) : rcnt;
`else
    assign rd_idx = AW'(digit_rev(32'(rcnt), LOG2R));
`endif

    // Next full flags and write bank; a write-side fill and a read-side drain never hit the same bank.
    always_comb begin
        full_nxt = full;
        wb_nxt   = wb;
        if (wr_wrap) begin
            full_nxt[wb] = 1'b1;
            wb_nxt       = !wb;
        end
        if (rd_wrap) full_nxt[rb] = 1'b0;
    end

    // Write side: slot counter, bank toggling, full flags, registered ready and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            wb        <= 1'b0;
            full      <= 2'b00;
            din_ready <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) wcnt <= wcnt + 1'b1;
            wb        <= wb_nxt;
            full      <= full_nxt;
            din_ready <= !full_nxt[wb_nxt];
            if (din_valid && !din_ready) ovf <= 1'b1;
        end
    end

    // Read side: step through the full bank whenever the output stage can take another sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt     <= '0;
            rb       <= 1'b0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
`ifdef FFT_REORDER_BYPASS_EN
            rev_q    <= 1'b1;
`endif
        end else if (adv) begin
            s1_valid <= issue;
            if (issue) begin
                rcnt    <= rcnt + 1'b1;
                s1_last <= (rcnt == {AW{1'b1}});
                if (rd_wrap) rb <= !rb;
`ifdef FFT_REORDER_BYPASS_EN
                if (rcnt == '0) rev_q <= reorder_en;
`endif
            end
        end
    end

    // Output register: load on advance, hold while stalled, keep data when the pipe runs dry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            dout_last  <= 1'b0;
        end else if (adv) begin
            dout_valid <= s1_valid;
            if (s1_valid) begin
                dout_re   <= rd_data[2*DW-1:DW];
                dout_im   <= rd_data[DW-1:0];
                dout_last <= s1_last;
            end
        end
    end

    fft_bank_ram #(
        .WIDTH (2 * DW),
        .AW    (AW + 1)
    ) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr ({wb, wcnt}),
        .wdata ({din_re, din_im}),
        .re    (issue),
        .raddr ({rb, rd_idx}),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Self-checking bench for fft_reorder_buf with a frame-level reference model.
// Build with FFT_REORDER_BYPASS_EN defined to also exercise the reorder_en port.
module tb_fft_reorder_buf;
    import fft_pkg::*;

    localparam int DW    = FFT_DW;
    localparam int LOG2R = FFT_LOG2R;
    localparam int R     = 1 << LOG2R;

    typedef struct {
        cplx_t d;
        logic  last;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din_re;
    logic [DW-1:0] din_im;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] dout_re;
    logic [DW-1:0] dout_im;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_last;
    logic          ovf;
`ifdef FFT_REORDER_BYPASS_EN
    logic          reorder_en;
`endif

    int            vectors;
    int            miscompares;
    int            outputs_seen;
    logic          model_rev;
    logic          held;
    logic [2*DW+1:0] held_val;
    cplx_t         frame_q[$];
    exp_t          exp_q[$];

    fft_reorder_buf dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_re     (din_re),
        .din_im     (din_im),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
`ifdef FFT_REORDER_BYPASS_EN
        .reorder_en (reorder_en),
`endif
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .ovf        (ovf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Offer one sample and return once it has been taken (called at posedge+1).
    task automatic applyStimulus(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int waited;
        waited    = 0;
        din_re    = re;
        din_im    = im;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && waited < 1000) begin
            waited++;
            @(negedge clk);
        end
        if (!din_ready) checkOutput("din_ready_timeout", 64'(din_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        checkOutput(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Reference model and output monitor: frames are collected as accepted, then queued
    // in read order; every transfer is compared and stalled outputs must not move.
    always @(negedge clk) begin
        cplx_t c;
        exp_t  e;
        int    idx;
        if (!rst_n) begin
            exp_q.delete();
            frame_q.delete();
            held = 1'b0;
        end else begin
            if (held)
                checkOutput("hold", 64'({dout_valid, dout_re, dout_im, dout_last}), 64'(held_val));
            if (dout_valid && dout_ready) begin
                outputs_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out", 64'(dout_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_sample", 64'({dout_re, dout_im, dout_last}),
                                64'({e.d.re, e.d.im, e.last}));
                end
            end
            held     = dout_valid && !dout_ready;
            held_val = {1'b1, dout_re, dout_im, dout_last};
            if (din_valid && din_ready) begin
                c.re = din_re;
                c.im = din_im;
                frame_q.push_back(c);
                if (frame_q.size() == N) begin
                    for (int j = 0; j < N; j++) begin
                        idx    = model_rev ? (j % R) * R + j / R : j;
                        e.d    = frame_q[idx];
                        e.last = (j == N - 1);
                        exp_q.push_back(e);
                    end
                    frame_q.delete();
                end
            end
        end
    end

    initial begin
        int gaps;
        int c;
        int base;
        logic done;
        vectors      = 0;
        miscompares  = 0;
        outputs_seen = 0;
        model_rev    = 1'b1;
        held         = 1'b0;
        held_val     = '0;
        rst_n        = 1'b1;
        din_re       = '0;
        din_im       = '0;
        din_valid    = 1'b0;
        dout_ready   = 1'b1;
`ifdef FFT_REORDER_BYPASS_EN
        reorder_en   = 1'b1;
`endif

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_dout_valid", 64'(dout_valid), 64'd0);
        checkOutput("rst_dout_re", 64'(dout_re), 64'd0);
        checkOutput("rst_dout_im", 64'(dout_im), 64'd0);
        checkOutput("rst_dout_last", 64'(dout_last), 64'd0);
        checkOutput("rst_din_ready", 64'(din_ready), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: ramp frame, latency of first output
        for (int k = 0; k < N; k++) applyStimulus(DW'(k), DW'(-k));
        din_valid = 1'b0;
        @(negedge clk);
        checkOutput("t1_lat_cyc0", 64'(dout_valid), 64'd0);
        @(negedge clk);
        checkOutput("t1_lat_cyc1", 64'(dout_valid), 64'd0);
        @(negedge clk);
        checkOutput("t1_lat_cyc2", 64'(dout_valid), 64'd1);
        checkOutput("t1_first_re", 64'(dout_re), 64'd0);
        waitDrain("t1_drain");
        checkOutput("t1_count", 64'(outputs_seen), 64'(N));
        @(posedge clk);
        #1;

        // Test 2: four back-to-back random frames, no output gaps
        base = outputs_seen;
        gaps = 0;
        fork
            begin
                for (int k = 0; k < 4 * N; k++) applyStimulus(DW'($urandom), DW'($urandom));
                din_valid = 1'b0;
            end
            begin
                c = 0;
                @(negedge clk);
                while (!dout_valid && c < 500) begin
                    c++;
                    @(negedge clk);
                end
                repeat (4 * N) begin
                    if (!dout_valid) gaps++;
                    @(negedge clk);
                end
            end
        join
        checkOutput("t2_gaps", 64'(gaps), 64'd0);
        waitDrain("t2_drain");
        checkOutput("t2_count", 64'(outputs_seen - base), 64'(4 * N));
        @(posedge clk);
        #1;

        // Test 3: output stalled, two frames fill both banks, extra samples overflow
        dout_ready = 1'b0;
        for (int k = 0; k < 2 * N; k++) applyStimulus(DW'($urandom), DW'($urandom));
        base = outputs_seen;
        for (int k = 0; k < 5; k++) begin
            din_re    = DW'($urandom);
            din_im    = DW'($urandom);
            din_valid = 1'b1;
            @(negedge clk);
            checkOutput("t3_ready_low", 64'(din_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t3_ovf", 64'(ovf), 64'd1);
        checkOutput("t3_hold_valid", 64'(dout_valid), 64'd1);
        checkOutput("t3_hold_first", 64'({dout_re, dout_im}), 64'({exp_q[0].d.re, exp_q[0].d.im}));
        dout_ready = 1'b1;
        waitDrain("t3_drain");
        checkOutput("t3_count", 64'(outputs_seen - base), 64'(2 * N));
        checkOutput("t3_ovf_sticky", 64'(ovf), 64'd1);
        @(posedge clk);
        #1;

        // Test 4: random downstream backpressure
        base = outputs_seen;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < N; k++) applyStimulus(DW'($urandom), DW'($urandom));
                din_valid = 1'b0;
                waitDrain("t4_drain");
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    dout_ready = 1'($urandom_range(0, 1));
                end
                dout_ready = 1'b1;
            end
        join
        checkOutput("t4_count", 64'(outputs_seen - base), 64'(N));
        @(posedge clk);
        #1;

        // Test 5: asynchronous reset in the middle of a frame
        for (int k = 0; k < 30; k++) applyStimulus(DW'($urandom | 1), DW'($urandom));
        din_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("t5_dout_valid", 64'(dout_valid), 64'd0);
        checkOutput("t5_dout_data", 64'({dout_re, dout_im, dout_last}), 64'd0);
        checkOutput("t5_din_ready", 64'(din_ready), 64'd0);
        checkOutput("t5_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_ready_after", 64'(din_ready), 64'd1);
        @(posedge clk);
        #1;
        base = outputs_seen;
        for (int k = 0; k < N; k++) applyStimulus(DW'(k), DW'(-k));
        din_valid = 1'b0;
        waitDrain("t5_drain");
        checkOutput("t5_count", 64'(outputs_seen - base), 64'(N));
        @(posedge clk);
        #1;

`ifdef FFT_REORDER_BYPASS_EN
        // Test 6: natural-order frame, then reversed frame with a mid-read toggle, then natural again
        reorder_en = 1'b0;
        model_rev  = 1'b0;
        for (int k = 0; k < N; k++) applyStimulus(DW'(k), DW'(-k));
        din_valid = 1'b0;
        waitDrain("t6_natural");
        @(posedge clk);
        #1;
        reorder_en = 1'b1;
        model_rev  = 1'b1;
        for (int k = 0; k < N; k++) applyStimulus(DW'(k), DW'(-k));
        din_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reorder_en = 1'b0;
        model_rev  = 1'b0;
        waitDrain("t6_reversed");
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) applyStimulus(DW'($urandom), DW'($urandom));
        din_valid = 1'b0;
        waitDrain("t6_natural2");
        @(posedge clk);
        #1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
